// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, FSM encoding and widths for the MIPS-subset fetch path
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory req/ready bus between sequencer and imem
interface fetch_sequencer_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// rtl/fetch_sequencer_next_pc_calc.sv - combinational next-PC select (jump > taken branch > pc+4)
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic [25:0]     i_instr,
    input  logic            i_branch,
    input  logic            i_jump,
    input  logic            i_zero,
    input  logic            i_illegal,
    output logic [XLEN-1:0] o_next_pc
);

    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_branch_off;
    logic [XLEN-1:0] w_jump_target;
    logic [XLEN-1:0] w_branch_target;

    assign w_pc4           = i_pc + 32'd4;
    assign w_branch_off    = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
    assign w_jump_target   = {w_pc4[31:28], i_instr[25:0], 2'b00};
    assign w_branch_target = w_pc4 + w_branch_off;

    // An unsupported opcode behaves as a NOP regardless of controller outputs
    always_comb begin
        o_next_pc = w_pc4;
        if (!i_illegal) begin
            if (i_jump) begin
                o_next_pc = w_jump_target;
            end else if (i_branch && i_zero) begin
                o_next_pc = w_branch_target;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multicycle fetch/PC sequencer; FETCH_TIMEOUT_EN adds an imem wait watchdog
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.master   imem,
    output logic [XLEN-1:0]     instr,
    output logic [5:0]          op,
    output logic                instr_valid,
    output logic [XLEN-1:0]     pc,
    input  logic                Branch,
    input  logic                Jump,
    input  logic                Zero,
    input  logic                stall,
    output logic                illegal_op,
    output logic                fault
);

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_illegal_op;
    logic            w_req;
    logic            w_parked;
    logic            w_fetch_done;
    logic            w_instr_illegal;
    logic [XLEN-1:0] w_next_pc;

    assign w_fetch_done    = (r_state == ST_FETCH) && imem.imem_ready && !w_parked;
    assign w_instr_illegal = !op_supported(r_instr[31:26]);

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_req = !w_parked;
                if (w_fetch_done) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_illegal_op <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_illegal_op <= 1'b0;
            // illegal_op is registered with the instruction so it covers only the first EXEC cycle
            if (w_fetch_done) begin
                r_instr      <= imem.imem_rdata;
                r_illegal_op <= !op_supported(imem.imem_rdata[31:26]);
            end
            if ((r_state == ST_EXEC) && !stall) begin
                r_pc <= w_next_pc;
            end
        end
    end

    next_pc_calc u_next_pc_calc (
        .i_pc      (r_pc),
        .i_instr   (r_instr[25:0]),
        .i_branch  (Branch),
        .i_jump    (Jump),
        .i_zero    (Zero),
        .i_illegal (w_instr_illegal),
        .o_next_pc (w_next_pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int             WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] r_wait;
    logic              r_fault;

    // Counter idles at zero outside FETCH, so every FETCH entry starts a fresh window
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else if (r_state != ST_FETCH) begin
            r_wait <= '0;
        end else if (!imem.imem_ready && !r_fault) begin
            if (r_wait == WAIT_LAST) begin
                r_fault <= 1'b1;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign w_parked = r_fault;
    assign fault    = r_fault;
`else
    // Watchdog compiled out: never park, fault reads constant 0 (TIMEOUT is never negative)
    assign w_parked = 1'b0;
    assign fault    = (TIMEOUT < 0);
`endif

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign instr          = r_instr;
    assign op             = r_instr[31:26];
    assign instr_valid    = (r_state == ST_EXEC);
    assign pc             = r_pc;
    assign illegal_op     = r_illegal_op;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed bench with cycle-level reference model for fetch_sequencer
module tb_fetch_sequencer;
    import mips_pkg::*;

    localparam int          TB_TIMEOUT  = 4;
    localparam logic [31:0] HI_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] W_RTYPE     = 32'h0000_0020;
`ifdef FETCH_TIMEOUT_EN
    localparam int          READY_LOW_N = 3;
`else
    localparam int          READY_LOW_N = 5;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] tb_rdata = W_RTYPE;
    logic        tb_ready = 1'b0;
    logic        tb_branch = 1'b0;
    logic        tb_jump = 1'b0;
    logic        tb_zero = 1'b0;
    logic        tb_stall = 1'b0;

    logic [31:0] instr, pc, instr_hi, pc_hi;
    logic [5:0]  op, op_hi;
    logic        instr_valid, illegal_op, fault;
    logic        instr_valid_hi, illegal_op_hi, fault_hi;

    fetch_sequencer_if imem_if ();
    fetch_sequencer_if imem_hi ();

    assign imem_if.imem_rdata = tb_rdata;
    assign imem_if.imem_ready = tb_ready;
    assign imem_hi.imem_rdata = tb_rdata;
    assign imem_hi.imem_ready = tb_ready;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TB_TIMEOUT)) u_dut (
        .clk(clk), .reset(reset), .imem(imem_if),
        .instr(instr), .op(op), .instr_valid(instr_valid), .pc(pc),
        .Branch(tb_branch), .Jump(tb_jump), .Zero(tb_zero), .stall(tb_stall),
        .illegal_op(illegal_op), .fault(fault)
    );

    fetch_sequencer #(.RESET_PC(HI_RESET_PC), .TIMEOUT(TB_TIMEOUT)) u_dut_hi (
        .clk(clk), .reset(reset), .imem(imem_hi),
        .instr(instr_hi), .op(op_hi), .instr_valid(instr_valid_hi), .pc(pc_hi),
        .Branch(tb_branch), .Jump(tb_jump), .Zero(tb_zero), .stall(tb_stall),
        .illegal_op(illegal_op_hi), .fault(fault_hi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=boot, 1=fetch, 2=exec
    logic [31:0] m_pc, m_instr;
    int          m_phase, m_wait;
    bit          m_ill, m_fault, m_live = 0;

    function automatic bit legal(input logic [5:0] o);
        logic [5:0] ops [5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        foreach (ops[i]) if (ops[i] == o) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input logic br, input logic jp, input logic z);
        longint seq, off;
        seq = (longint'(cur) + 4) % 64'h1_0000_0000;
        if (!legal(w[31:26])) return 32'(seq);
        if (jp) return 32'((seq / 64'h1000_0000) * 64'h1000_0000 + longint'(w[25:0]) * 4);
        if (br && z) begin
            off = longint'($signed(w[15:0])) * 4;
            return 32'((seq + off + 64'h1_0000_0000) % 64'h1_0000_0000);
        end
        return 32'(seq);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_pc = 32'h0; m_instr = 32'h0;
            m_ill = 0; m_fault = 0; m_wait = 0; m_live = 1;
        end else begin
            m_ill = 0;
            case (m_phase)
                0: begin m_phase = 1; m_wait = 0; end
                1: if (!m_fault) begin
                    if (tb_ready) begin
                        m_instr = tb_rdata;
                        m_ill   = !legal(tb_rdata[31:26]);
                        m_phase = 2;
                    end else begin
                        m_wait++;
`ifdef FETCH_TIMEOUT_EN
                        if (m_wait == TB_TIMEOUT) m_fault = 1;
`endif
                    end
                end
                default: if (!tb_stall) begin
                    m_pc    = model_next(m_pc, m_instr, tb_branch, tb_jump, tb_zero);
                    m_phase = 1;
                    m_wait  = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check1("m_imem_req", imem_if.imem_req, (m_phase == 1) && !m_fault);
            check32("m_imem_addr", imem_if.imem_addr, m_pc);
            check32("m_pc", pc, m_pc);
            check1("m_instr_valid", instr_valid, m_phase == 2);
            check32("m_instr", instr, m_instr);
            check32("m_op", {26'd0, op}, {26'd0, m_instr[31:26]});
            check1("m_illegal_op", illegal_op, m_ill);
            check1("m_fault", fault, m_fault);
        end
    end

    task automatic exec_instr(input logic [31:0] word, input logic br, input logic jp,
                              input logic z, input int stalls,
                              output int valid_cnt, output int ill_cnt);
        valid_cnt = 0;
        ill_cnt   = 0;
        tb_rdata  = word;
        tb_ready  = 1'b1;
        @(negedge clk);
        valid_cnt += int'(instr_valid);
        ill_cnt   += int'(illegal_op);
        tb_branch = br; tb_jump = jp; tb_zero = z;
        for (int i = 0; i < stalls; i++) begin
            tb_stall = 1'b1;
            @(negedge clk);
            valid_cnt += int'(instr_valid);
            ill_cnt   += int'(illegal_op);
        end
        tb_stall = 1'b0;
        @(negedge clk);
        tb_branch = 1'b0; tb_jump = 1'b0; tb_zero = 1'b0;
        tb_rdata  = W_RTYPE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int vc, ic;
        @(negedge clk);
        @(negedge clk);
        check1("rst_req", imem_if.imem_req, 1'b0);
        check32("rst_pc", pc, 32'h0);
        check1("rst_valid", instr_valid, 1'b0);
        check32("rst_instr", instr, 32'h0);
        check1("rst_fault", fault, 1'b0);
        check32("rst_hi_pc", pc_hi, HI_RESET_PC);
        reset = 1'b0;
        tb_ready = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            check1("seq_req", imem_if.imem_req, 1'b1);
            check32("seq_addr", imem_if.imem_addr, 32'(k * 4));
            check1("seq_fetch_not_valid", instr_valid, 1'b0);
            exec_instr(W_RTYPE, 1'b0, 1'b0, 1'b0, 0, vc, ic);
            check32("seq_valid_cycles", 32'(vc), 32'd1);
        end
        check32("seq_end_addr", imem_if.imem_addr, 32'h10);

        exec_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 0, vc, ic);
        check32("beq_taken", imem_if.imem_addr, 32'h0C);
        exec_instr(W_RTYPE, 1'b0, 1'b0, 1'b0, 0, vc, ic);
        exec_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 0, vc, ic);
        check32("beq_not_taken", imem_if.imem_addr, 32'h14);

        tb_ready = 1'b0;
        for (int i = 0; i < READY_LOW_N; i++) begin
            @(negedge clk);
            check1("wait_req_held", imem_if.imem_req, 1'b1);
            check32("wait_addr_stable", imem_if.imem_addr, 32'h14);
        end
        exec_instr(W_RTYPE, 1'b0, 1'b0, 1'b0, 3, vc, ic);
        check32("stall_valid_cycles", 32'(vc), 32'd4);
        check32("stall_then_advance", imem_if.imem_addr, 32'h18);

        exec_instr(32'hFC00_0000, 1'b1, 1'b1, 1'b1, 0, vc, ic);
        check32("illegal_pulse_cycles", 32'(ic), 32'd1);
        check32("illegal_as_nop", imem_if.imem_addr, 32'h1C);
        check1("illegal_low_after", illegal_op, 1'b0);

        tb_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check1("pre_reset_req", imem_if.imem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check1("midfetch_reset_req", imem_if.imem_req, 1'b0);
        check32("midfetch_reset_pc", pc, 32'h0);
        reset = 1'b0;
        tb_ready = 1'b1;
        @(negedge clk);

        check32("hi_start_addr", imem_hi.imem_addr, HI_RESET_PC);
        exec_instr(32'h0800_0100, 1'b1, 1'b1, 1'b1, 0, vc, ic);
        check32("jump_lo", imem_if.imem_addr, 32'h0000_0400);
        check32("jump_hi_priority", pc_hi, 32'h4000_0400);

        exec_instr(32'h1000_FEFE, 1'b1, 1'b0, 1'b1, 0, vc, ic);
        check32("branch_to_top", imem_if.imem_addr, 32'hFFFF_FFFC);
        exec_instr(W_RTYPE, 1'b0, 1'b0, 1'b0, 0, vc, ic);
        check32("pc_wrap", imem_if.imem_addr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        tb_ready = 1'b0;
        for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
            @(negedge clk);
            check1("to_no_fault_yet", fault, 1'b0);
        end
        @(negedge clk);
        check1("to_fault_rises", fault, 1'b1);
        check1("to_req_drops", imem_if.imem_req, 1'b0);
        tb_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("to_fault_sticky", fault, 1'b1);
        check1("to_parked", instr_valid, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check1("to_fault_cleared", fault, 1'b0);
        reset = 1'b0;
        @(negedge clk);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and PC sequencing unit for the MIPS-subset core.
- Fetches 32-bit words from instruction memory over a req/ready handshake and presents the opcode field to the main controller.
- Consumes the controller's Branch/Jump outputs, plus the ALU Zero flag, to select the next PC.
- Multicycle: one instruction in flight; no pipelining.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT, 16, max imem wait cycles before fault; used only with the optional feature.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high until accepted.
- imem_addr  output  32  fetch address, equal to pc.
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- imem_ready  input  1  memory accepts the request and returns data in the same cycle.
- instr  output  32  latched instruction.
- op  output  6  instr[31:26]; feeds the controller.
- instr_valid  output  1  instr/op valid; high for the whole EXEC state.
- pc  output  32  current PC.
- Branch  input  1  from controller.
- Jump  input  1  from controller.
- Zero  input  1  ALU zero flag.
- stall  input  1  holds EXEC; no PC update.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- fault  output  1  sticky timeout fault; optional feature only, else tied 0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset values: state=BOOT, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, illegal_op=0, fault=0.
- States: BOOT, FETCH, EXEC.
- BOOT: always goes to FETCH on the next edge.
- FETCH:
  - imem_req=1 and imem_addr=pc, combinationally from state.
  - When imem_ready=1: instr<=imem_rdata, go to EXEC.
  - Otherwise stay in FETCH with req held high and address stable.
- EXEC:
  - instr_valid=1.
  - If stall=1: stay in EXEC; pc and instr hold.
  - Else: pc<=next_pc, go to FETCH.
- next_pc priority:
  - Jump=1: {pc4[31:28], instr[25:0], 2'b00}.
  - Else Branch=1 and Zero=1: pc4 + (sign_extend(instr[15:0]) << 2).
  - Else: pc4.
  - pc4 = pc + 4.
  - All arithmetic is 32-bit modulo; wrap at 32'hFFFF_FFFC to 0 with no flag.
- Jump and Branch both high: Jump wins.
- Supported opcodes: 000000, 100011, 101011, 000100, 000010.
  - Any other opcode: illegal_op pulses in the first EXEC cycle only.
  - Control inputs are ignored and next_pc=pc4, i.e. the instruction executes as a NOP.
- Minimum throughput: 2 cycles per instruction (FETCH with ready, then EXEC).
- Reset mid-FETCH: the request is abandoned; imem_req=0 in the cycle after reset is sampled.
- Reset mid-EXEC: the in-flight PC update is discarded.
- imem_ready outside FETCH is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH and increments each FETCH cycle with imem_ready=0.
  - When it reaches TIMEOUT: fault<=1 (sticky until reset), imem_req drops, and the FSM parks in FETCH with no further requests.
- Undefined: no counter; fault is constant 0; FETCH waits indefinitely.

Decomposition:
- Shared package (mips_pkg):
  - Opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010.
  - FSM state encoding.
  - Width constant XLEN=32.
- One sub-module, next_pc_calc (combinational):
  - Inputs: pc, instr, Branch, Jump, Zero, illegal flag.
  - Output: next_pc.

Test Plan:
- Reset, then imem_ready tied 1 and memory holding R-type 32'h0000_0020 at every address → pc sequence 0, 4, 8, 12, with 2 cycles per step and instr_valid high every other cycle.
- At pc=0x10: beq with imm=16'hFFFE, Branch=1, Zero=1 → pc becomes 0x0C. Same with Zero=0 → pc becomes 0x14.
- At pc=0x4000_0000: j with target 26'h000_0100, Jump=1, Branch=1 → pc becomes 0x4000_0400 (Jump priority).
- imem_ready low for 5 cycles → imem_req stays high and imem_addr stable. Assert stall for 3 cycles in EXEC → pc unchanged, instr_valid high for 4 cycles.
- Opcode 6'b111111 → illegal_op high for exactly 1 cycle and pc advances by 4. Assert reset during a FETCH wait → the cycle after reset is sampled shows imem_req=0 and pc=RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT=4: imem_ready held 0 → fault rises after 4 wait cycles, imem_req drops, and fault stays high until reset.
